anabellek_hakem: RTL and testbench
==================================

# anabellek_hakem

Arbiter sharing the single main-memory (anabellek) port between the instruction-cache controller and the data-cache controller. Each client sees the same 128-bit block handshake (musait / istek / hazir / obek) it would see from a private memory. The block latches one request at a time, drives it to memory, and returns the response to the owning client. Grants alternate round-robin so neither client starves.

## Interface
- ADRES_W, 32, address width
- OBEK_W, 128, block (line) width
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- buyruk_istek_i  in  1  instruction-side request, held until buyruk_hazir_o
- buyruk_adres_i  in  ADRES_W  instruction block address, low 4 bits are 0
- buyruk_musait_o  out  1  arbiter can accept a request
- buyruk_hazir_o  out  1  one-cycle response strobe
- buyruk_obek_o  out  OBEK_W  read block, valid only with buyruk_hazir_o, else 0
- veri_istek_i  in  1  data-side request, held until veri_hazir_o
- veri_adres_i  in  ADRES_W  data block address
- veri_yaz_i  in  1  1 = block write, 0 = block read
- veri_obek_i  in  OBEK_W  write block
- veri_musait_o  out  1  arbiter can accept a request
- veri_hazir_o  out  1  one-cycle response strobe (read or write complete)
- veri_obek_o  out  OBEK_W  read block, valid only with veri_hazir_o, else 0
- bellek_musait_i  in  1  memory can take a new transaction
- bellek_hazir_i  in  1  memory transaction complete
- bellek_obek_i  in  OBEK_W  memory read data, valid with bellek_hazir_i
- bellek_istek_o  out  1  memory request, registered
- bellek_adres_o  out  ADRES_W  latched address, registered
- bellek_yaz_o  out  1  latched write flag, registered
- bellek_veri_o  out  OBEK_W  latched write block, registered
- bellek_oku_o  out  1  equals !bellek_yaz_o while bellek_istek_o is high, else 0

## Operation
- States are BOSTA (00), BUYRUK_SERVIS (01) and VERI_SERVIS (10). Encoding 11 is unreachable and returns to BOSTA.
- oncelik_r (1 bit): 0 = instruction side preferred, 1 = data side preferred. Reset value is 0.
- Both *_musait_o equal (durum_r == BOSTA) && bellek_musait_i.
- In BOSTA, with bellek_musait_i = 1:
  - If exactly one istek is high, that side is granted.
  - If both are high, the side named by oncelik_r is granted.
- On grant, the following are latched at the clock edge:
  - address;
  - yaz (0 for the instruction side);
  - write block (0 for the instruction side).
- On grant, bellek_istek_o is set to 1 and the state moves to the matching SERVIS state.
- In BOSTA with bellek_musait_i = 0, nothing is granted and the state stays in BOSTA.
- In a SERVIS state:
  - bellek_istek_o and the latched outputs stay constant until bellek_hazir_i.
  - On bellek_hazir_i, the owner's hazir_o is driven combinationally in the same cycle.
  - For a read, the owner's obek_o = bellek_obek_i; for a write, obek_o = 0.
  - At the next edge: bellek_istek_o clears, the state returns to BOSTA, and oncelik_r is set to the side not just served.
- The losing requester keeps istek high and is granted on the first BOSTA cycle after completion. This gives strict alternation under continuous contention.
- Once latched, a transaction always completes, even if the client drops istek mid-transaction. The hazir pulse is still delivered.
- bellek_hazir_i outside a SERVIS state is ignored and produces no client hazir.
- Client hazir_o and obek_o are never driven for the non-owning side.

## Timing
- The grant decision is combinational on the istek, musait and oncelik_r inputs. All bellek_* outputs are registered.
- Minimum latency:
  - istek high in BOSTA at cycle N → bellek_istek_o high at N+1.
  - Fastest memory (bellek_hazir_i at N+1) → client hazir at N+1, BOSTA at N+2.
  - Next grant possible at N+2.
- Back-to-back transactions: one idle BOSTA cycle between transactions.
- Reset values, taking effect at the edge with rst_i = 1:
  - state BOSTA;
  - oncelik_r 0;
  - bellek_istek_o, bellek_yaz_o, bellek_oku_o 0;
  - bellek_adres_o 0;
  - bellek_veri_o 0;
  - all hazir_o 0 and obek_o 0.
- Reset mid-transaction: the transaction is abandoned with no client hazir, and bellek_istek_o is 0 from the next cycle.
- rst_i dominates all other inputs in the same cycle.

## Test plan
- Single instruction read: buyruk_istek_i = 1 with address 0x0000_1230, memory hazir 3 cycles after bellek_istek_o, data 0xA5..A5 → bellek_adres_o = 0x0000_1230 and bellek_oku_o = 1 for 3 cycles, buyruk_hazir_o one pulse with obek 0xA5..A5, veri_hazir_o stays 0.
- Simultaneous requests after reset: both istek high at cycle N → instruction side served first, data side granted at the first BOSTA cycle after that, then oncelik_r = 0 again.
- Data write: veri_yaz_i = 1, address 0x8000_0040, block 0x0123..CDEF → bellek_yaz_o = 1, bellek_oku_o = 0, bellek_veri_o latched, veri_hazir_o pulses with veri_obek_o = 0.
- Client drops istek mid-transaction: buyruk_istek_i cleared 1 cycle after grant → bellek_istek_o is held until bellek_hazir_i and buyruk_hazir_o still pulses.
- Memory busy: bellek_musait_i = 0 for 5 cycles with veri_istek_i high → both musait_o = 0, no grant; grant occurs in the cycle bellek_musait_i rises.
- Reset mid-transaction: rst_i = 1 during VERI_SERVIS → next cycle bellek_istek_o = 0, state BOSTA, no veri_hazir_o; a late bellek_hazir_i is ignored.

Source files
------------

// File: rtl/anabellek_hakem.sv
// anabellek_hakem: shares one main-memory port between the instruction-cache
// controller (buyruk) and the data-cache controller (veri).
//
// One request is latched at a time, driven to memory on registered bellek_*
// outputs, and the memory response is routed back to the owning client only.
// When both clients ask in the same idle cycle, oncelik_q picks the winner;
// it flips to the other side after every completion, so continuous contention
// alternates strictly between the two clients.
//
// Client handshake (same on both sides): a client raises *_istek_i with its
// address/data and holds them until it sees its one-cycle *_hazir_o strobe.
// A request is accepted on an edge where the arbiter is idle, memory reports
// bellek_musait_i, and this side wins; *_musait_o shows the first two terms.
// Once accepted, the transaction always completes even if istek drops.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   buyruk_istek_i/adres_i       instruction-side read request and address
//   buyruk_musait_o/hazir_o/obek_o  instruction-side ready, strobe, read block
//   veri_istek_i/adres_i/yaz_i/obek_i  data-side request, address, write flag, write block
//   veri_musait_o/hazir_o/obek_o  data-side ready, strobe, read block
//   bellek_musait_i/hazir_i/obek_i  memory ready, completion, read data
//   bellek_istek_o/adres_o/yaz_o/veri_o/oku_o  registered memory request side

module anabellek_hakem #(
    parameter int ADRES_W = 32,
    parameter int OBEK_W  = 128
) (
    input  logic               clk_i,
    input  logic               rst_i,

    input  logic               buyruk_istek_i,
    input  logic [ADRES_W-1:0] buyruk_adres_i,
    output logic               buyruk_musait_o,
    output logic               buyruk_hazir_o,
    output logic [OBEK_W-1:0]  buyruk_obek_o,

    input  logic               veri_istek_i,
    input  logic [ADRES_W-1:0] veri_adres_i,
    input  logic               veri_yaz_i,
    input  logic [OBEK_W-1:0]  veri_obek_i,
    output logic               veri_musait_o,
    output logic               veri_hazir_o,
    output logic [OBEK_W-1:0]  veri_obek_o,

    input  logic               bellek_musait_i,
    input  logic               bellek_hazir_i,
    input  logic [OBEK_W-1:0]  bellek_obek_i,
    output logic               bellek_istek_o,
    output logic [ADRES_W-1:0] bellek_adres_o,
    output logic               bellek_yaz_o,
    output logic [OBEK_W-1:0]  bellek_veri_o,
    output logic               bellek_oku_o
);

    typedef enum logic [1:0] {
        BOSTA         = 2'b00,
        BUYRUK_SERVIS = 2'b01,
        VERI_SERVIS   = 2'b10
    } durum_e;

    durum_e             durum_q, durum_d;
    logic               oncelik_q, oncelik_d;   // 0: buyruk preferred, 1: veri preferred
    logic               istek_q, istek_d;
    logic [ADRES_W-1:0] adres_q, adres_d;
    logic               yaz_q, yaz_d;
    logic [OBEK_W-1:0]  veri_q, veri_d;

    logic               kabul;          // idle and memory can take a transaction
    logic               buyruk_kazan;
    logic               veri_kazan;
    logic               bitti;          // owner's transaction completes this cycle

    assign kabul           = (durum_q == BOSTA) && bellek_musait_i;
    assign buyruk_musait_o = kabul;
    assign veri_musait_o   = kabul;

    // Single requester wins outright; on a tie oncelik_q decides.
    assign buyruk_kazan = kabul && buyruk_istek_i && (!veri_istek_i || !oncelik_q);
    assign veri_kazan   = kabul && veri_istek_i && (!buyruk_istek_i || oncelik_q);

    // Reset dominates: a completion arriving in a reset cycle is dropped.
    assign bitti = bellek_hazir_i && !rst_i;

    always_comb begin
        durum_d        = durum_q;
        oncelik_d      = oncelik_q;
        istek_d        = istek_q;
        adres_d        = adres_q;
        yaz_d          = yaz_q;
        veri_d         = veri_q;
        buyruk_hazir_o = 1'b0;
        buyruk_obek_o  = '0;
        veri_hazir_o   = 1'b0;
        veri_obek_o    = '0;

        case (durum_q)
            BOSTA: begin
                if (buyruk_kazan) begin
                    durum_d = BUYRUK_SERVIS;
                    istek_d = 1'b1;
                    adres_d = buyruk_adres_i;
                    yaz_d   = 1'b0;
                    veri_d  = '0;
                end else if (veri_kazan) begin
                    durum_d = VERI_SERVIS;
                    istek_d = 1'b1;
                    adres_d = veri_adres_i;
                    yaz_d   = veri_yaz_i;
                    veri_d  = veri_obek_i;
                end
            end
            BUYRUK_SERVIS: begin
                if (bitti) begin
                    buyruk_hazir_o = 1'b1;
                    buyruk_obek_o  = yaz_q ? '0 : bellek_obek_i;
                    durum_d        = BOSTA;
                    istek_d        = 1'b0;
                    oncelik_d      = 1'b1;
                end
            end
            VERI_SERVIS: begin
                if (bitti) begin
                    veri_hazir_o = 1'b1;
                    veri_obek_o  = yaz_q ? '0 : bellek_obek_i;
                    durum_d      = BOSTA;
                    istek_d      = 1'b0;
                    oncelik_d    = 1'b0;
                end
            end
            default: begin
                // Unreachable encoding: recover to idle without a request.
                durum_d = BOSTA;
                istek_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            durum_q   <= BOSTA;
            oncelik_q <= 1'b0;
            istek_q   <= 1'b0;
            adres_q   <= '0;
            yaz_q     <= 1'b0;
            veri_q    <= '0;
        end else begin
            durum_q   <= durum_d;
            oncelik_q <= oncelik_d;
            istek_q   <= istek_d;
            adres_q   <= adres_d;
            yaz_q     <= yaz_d;
            veri_q    <= veri_d;
        end
    end

    assign bellek_istek_o = istek_q;
    assign bellek_adres_o = adres_q;
    assign bellek_yaz_o   = yaz_q;
    assign bellek_veri_o  = veri_q;
    assign bellek_oku_o   = istek_q && !yaz_q;

endmodule

// File: tb/tb_anabellek_hakem.sv
// Testbench for anabellek_hakem: directed scenarios with literal expectations,
// then randomized traffic; a transaction-level model checks every cycle.
module tb_anabellek_hakem;

    localparam int AW = 32;
    localparam int OW = 128;

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic          buyruk_istek_i = 1'b0;
    logic [AW-1:0] buyruk_adres_i = '0;
    logic          buyruk_musait_o, buyruk_hazir_o;
    logic [OW-1:0] buyruk_obek_o;
    logic          veri_istek_i = 1'b0;
    logic [AW-1:0] veri_adres_i = '0;
    logic          veri_yaz_i = 1'b0;
    logic [OW-1:0] veri_obek_i = '0;
    logic          veri_musait_o, veri_hazir_o;
    logic [OW-1:0] veri_obek_o;
    logic          bellek_musait_i = 1'b1;
    logic          bellek_hazir_i = 1'b0;
    logic [OW-1:0] bellek_obek_i = '0;
    logic          bellek_istek_o, bellek_yaz_o, bellek_oku_o;
    logic [AW-1:0] bellek_adres_o;
    logic [OW-1:0] bellek_veri_o;

    anabellek_hakem #(.ADRES_W(AW), .OBEK_W(OW)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .buyruk_istek_i(buyruk_istek_i), .buyruk_adres_i(buyruk_adres_i),
        .buyruk_musait_o(buyruk_musait_o), .buyruk_hazir_o(buyruk_hazir_o),
        .buyruk_obek_o(buyruk_obek_o),
        .veri_istek_i(veri_istek_i), .veri_adres_i(veri_adres_i),
        .veri_yaz_i(veri_yaz_i), .veri_obek_i(veri_obek_i),
        .veri_musait_o(veri_musait_o), .veri_hazir_o(veri_hazir_o),
        .veri_obek_o(veri_obek_o),
        .bellek_musait_i(bellek_musait_i), .bellek_hazir_i(bellek_hazir_i),
        .bellek_obek_i(bellek_obek_i),
        .bellek_istek_o(bellek_istek_o), .bellek_adres_o(bellek_adres_o),
        .bellek_yaz_o(bellek_yaz_o), .bellek_veri_o(bellek_veri_o),
        .bellek_oku_o(bellek_oku_o)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- memory responder ----------------
    int            fixed_lat  = 0;     // 0 = random latency 1..4
    bit            fixed_data = 1'b0;
    logic [OW-1:0] mem_data   = '0;
    bit            spurious   = 1'b0;  // random completions while no request
    bit            force_hz   = 1'b0;
    int            cyc        = 0;
    int            cur_lat    = 1;

    initial forever begin
        @(posedge clk);
        #1;
        if (bellek_istek_o === 1'b1) begin
            cyc++;
            if (cyc == 1) cur_lat = (fixed_lat != 0) ? fixed_lat : $urandom_range(1, 4);
            bellek_hazir_i = (cyc == cur_lat) || force_hz;
        end else begin
            cyc = 0;
            bellek_hazir_i = force_hz || (spurious && ($urandom_range(0, 7) == 0));
        end
        bellek_obek_i = fixed_data ? mem_data : {$urandom(), $urandom(), $urandom(), $urandom()};
    end

    // ---------------- reference model and per-cycle compare ----------------
    // Model keeps only who owns memory, the pending preference and the
    // transaction that was handed to memory.
    int            m_own = 0;          // 0 none, 1 buyruk, 2 veri
    bit            m_prio = 1'b0;      // 1 = data side wins a tie
    logic [AW-1:0] m_adres = '0;
    logic          m_yaz = 1'b0;
    logic [OW-1:0] m_veri = '0;
    bit            started = 1'b0;

    always @(negedge clk) begin : cmp
        logic done;
        int   pick;
        done = !rst_i && (m_own != 0) && bellek_hazir_i;
        if (started) begin
            check("buyruk_musait", buyruk_musait_o, (m_own == 0) && bellek_musait_i);
            check("veri_musait", veri_musait_o, (m_own == 0) && bellek_musait_i);
            check("buyruk_hazir", buyruk_hazir_o, done && (m_own == 1));
            check("buyruk_obek", buyruk_obek_o, (done && m_own == 1) ? bellek_obek_i : 128'd0);
            check("veri_hazir", veri_hazir_o, done && (m_own == 2));
            check("veri_obek", veri_obek_o, (done && m_own == 2 && !m_yaz) ? bellek_obek_i : 128'd0);
            check("bellek_istek", bellek_istek_o, m_own != 0);
            check("bellek_adres", bellek_adres_o, m_adres);
            check("bellek_yaz", bellek_yaz_o, m_yaz);
            check("bellek_veri", bellek_veri_o, m_veri);
            check("bellek_oku", bellek_oku_o, (m_own != 0) && !m_yaz);
        end
        // advance to the state after the coming rising edge
        if (rst_i) begin
            m_own = 0; m_prio = 1'b0; m_adres = '0; m_yaz = 1'b0; m_veri = '0;
            started = 1'b1;
        end else if (m_own != 0) begin
            if (bellek_hazir_i) begin
                m_prio = (m_own == 1);
                m_own  = 0;
            end
        end else if (bellek_musait_i) begin
            if (buyruk_istek_i && veri_istek_i) pick = m_prio ? 2 : 1;
            else if (buyruk_istek_i)            pick = 1;
            else if (veri_istek_i)              pick = 2;
            else                                pick = 0;
            if (pick == 1) begin
                m_own = 1; m_adres = buyruk_adres_i; m_yaz = 1'b0; m_veri = '0;
            end else if (pick == 2) begin
                m_own = 2; m_adres = veri_adres_i; m_yaz = veri_yaz_i; m_veri = veri_obek_i;
            end
        end
    end

    // ---------------- driver tasks and recorders ----------------
    int            tcount = 0;
    bit            prev_istek = 1'b0;
    logic [AW-1:0] grant_q[$];
    int            grant_t[$];
    int            bh_t[$];
    int            vh_t[$];
    int            istek_cyc, oku_cyc;
    logic          g_yaz, g_oku;
    logic [OW-1:0] g_veri, b_obek, v_obek;

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic reset_rec();
        tcount = 0; prev_istek = bellek_istek_o;
        grant_q.delete(); grant_t.delete(); bh_t.delete(); vh_t.delete();
        istek_cyc = 0; oku_cyc = 0;
        g_yaz = 1'bx; g_oku = 1'bx; g_veri = 'x; b_obek = 'x; v_obek = 'x;
    endtask

    // Advance n cycles, recording grants and strobes; a client drops its
    // request once it sees its strobe.
    task automatic run(input int n);
        for (int c = 0; c < n; c++) begin
            step();
            tcount++;
            if (bellek_istek_o) istek_cyc++;
            if (bellek_oku_o) oku_cyc++;
            if (bellek_istek_o && !prev_istek) begin
                grant_q.push_back(bellek_adres_o);
                grant_t.push_back(tcount);
                g_yaz = bellek_yaz_o; g_oku = bellek_oku_o; g_veri = bellek_veri_o;
            end
            prev_istek = bellek_istek_o;
            if (buyruk_hazir_o) begin
                bh_t.push_back(tcount); b_obek = buyruk_obek_o; buyruk_istek_i = 1'b0;
            end
            if (veri_hazir_o) begin
                vh_t.push_back(tcount); v_obek = veri_obek_o; veri_istek_i = 1'b0;
            end
        end
    endtask

    // ---------------- main sequence ----------------
    localparam logic [OW-1:0] A5   = {16{8'hA5}};
    localparam logic [OW-1:0] WBLK = 128'h0123456789ABCDEF0123456789ABCDEF;

    initial begin
        rst_i = 1'b1;
        step(); step();
        rst_i = 1'b0;
        step();

        // reset values
        check("rst_istek", bellek_istek_o, 1'b0);
        check("rst_adres", bellek_adres_o, 32'h0);
        check("rst_yaz", bellek_yaz_o, 1'b0);
        check("rst_oku", bellek_oku_o, 1'b0);
        check("rst_veri", bellek_veri_o, 128'h0);
        check("rst_musait", buyruk_musait_o, 1'b1);
        check("rst_bhazir", buyruk_hazir_o, 1'b0);
        check("rst_vhazir", veri_hazir_o, 1'b0);

        // single instruction read, memory answers on 3rd request cycle
        fixed_lat = 3; fixed_data = 1'b1; mem_data = A5;
        reset_rec();
        buyruk_istek_i = 1'b1; buyruk_adres_i = 32'h0000_1230;
        run(10);
        check("t1_grant_t", (grant_t.size() > 0) ? grant_t[0] : -1, 1);
        check("t1_adres", (grant_q.size() > 0) ? grant_q[0] : 32'hDEAD_BEEF, 32'h0000_1230);
        check("t1_oku_cyc", oku_cyc, 3);
        check("t1_bh_cnt", bh_t.size(), 1);
        check("t1_bh_t", (bh_t.size() > 0) ? bh_t[0] : -1, 3);
        check("t1_obek", b_obek, A5);
        check("t1_vh_cnt", vh_t.size(), 0);

        // simultaneous requests after reset: buyruk first, then veri
        fixed_data = 1'b0; fixed_lat = 2;
        rst_i = 1'b1; step(); rst_i = 1'b0;
        reset_rec();
        buyruk_istek_i = 1'b1; buyruk_adres_i = 32'h0000_0100;
        veri_istek_i = 1'b1; veri_adres_i = 32'h0000_0200; veri_yaz_i = 1'b0;
        run(10);
        check("t2_first", (grant_q.size() > 0) ? grant_q[0] : 32'hDEAD_BEEF, 32'h0000_0100);
        check("t2_second", (grant_q.size() > 1) ? grant_q[1] : 32'hDEAD_BEEF, 32'h0000_0200);
        check("t2_bh_t", (bh_t.size() > 0) ? bh_t[0] : -1, 2);
        check("t2_g2_t", (grant_t.size() > 1) ? grant_t[1] : -1, 4);
        check("t2_vh_t", (vh_t.size() > 0) ? vh_t[0] : -1, 5);
        reset_rec();
        buyruk_istek_i = 1'b1; veri_istek_i = 1'b1;
        run(10);
        check("t2_prio_back", (grant_q.size() > 0) ? grant_q[0] : 32'hDEAD_BEEF, 32'h0000_0100);

        // data write
        reset_rec();
        veri_istek_i = 1'b1; veri_yaz_i = 1'b1; veri_adres_i = 32'h8000_0040; veri_obek_i = WBLK;
        run(6);
        veri_yaz_i = 1'b0;
        check("t3_adres", (grant_q.size() > 0) ? grant_q[0] : 32'hDEAD_BEEF, 32'h8000_0040);
        check("t3_yaz", g_yaz, 1'b1);
        check("t3_oku", g_oku, 1'b0);
        check("t3_veri", g_veri, WBLK);
        check("t3_vh_cnt", vh_t.size(), 1);
        check("t3_obek", v_obek, 128'h0);

        // client drops request one cycle after grant
        fixed_lat = 4;
        reset_rec();
        buyruk_istek_i = 1'b1; buyruk_adres_i = 32'h0000_3000;
        run(1);
        buyruk_istek_i = 1'b0;
        run(8);
        check("t4_istek_cyc", istek_cyc, 4);
        check("t4_bh_cnt", bh_t.size(), 1);

        // memory busy for 5 cycles
        fixed_lat = 2;
        bellek_musait_i = 1'b0;
        veri_istek_i = 1'b1; veri_adres_i = 32'h0000_0440; veri_yaz_i = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            check("t5_bmusait", buyruk_musait_o, 1'b0);
            check("t5_vmusait", veri_musait_o, 1'b0);
            check("t5_istek", bellek_istek_o, 1'b0);
        end
        bellek_musait_i = 1'b1;
        reset_rec();
        run(1);
        check("t5_grant", grant_t.size(), 1);
        run(6);
        check("t5_done", vh_t.size(), 1);

        // reset in the middle of a data read, then a late completion
        fixed_lat = 10;
        reset_rec();
        veri_istek_i = 1'b1; veri_adres_i = 32'h0000_0500; veri_yaz_i = 1'b0;
        run(2);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        check("t6_istek", bellek_istek_o, 1'b0);
        check("t6_bosta", veri_musait_o, 1'b1);
        check("t6_no_hz", vh_t.size(), 0);
        veri_istek_i = 1'b0;
        force_hz = 1'b1;
        step();
        check("t6_late_v", veri_hazir_o, 1'b0);
        check("t6_late_b", buyruk_hazir_o, 1'b0);
        force_hz = 1'b0;
        step();

        // randomized traffic, checked each cycle by the model
        fixed_lat = 0; spurious = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            step();
            if (buyruk_hazir_o || !buyruk_istek_i) begin
                buyruk_istek_i = ($urandom_range(0, 2) == 0);
                buyruk_adres_i = $urandom() & 32'hFFFF_FFF0;
            end
            if (veri_hazir_o || !veri_istek_i) begin
                veri_istek_i = ($urandom_range(0, 2) == 0);
                veri_adres_i = $urandom() & 32'hFFFF_FFF0;
                veri_yaz_i   = $urandom_range(0, 1);
                veri_obek_i  = {$urandom(), $urandom(), $urandom(), $urandom()};
            end
            bellek_musait_i = ($urandom_range(0, 9) != 0);
            rst_i = ($urandom_range(0, 299) == 0);
        end
        rst_i = 1'b0;
        spurious = 1'b0;
        step(); step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
